// File: rtl/exe_muldiv_sequencer_pkg.sv
// Shared encodings for the EXE-side multi-cycle mul/div sequencer.
// Op codes, FSM state codes, default word length, counter sizing.
package exe_muldiv_sequencer_pkg;

  localparam int MD_WORDLENGTH = 32;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam logic [1:0] MD_IDLE = 2'b00;
  localparam logic [1:0] MD_RUN  = 2'b01;
  localparam logic [1:0] MD_FIX  = 2'b10;
  localparam logic [1:0] MD_DONE = 2'b11;

  function automatic int md_cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

  function automatic logic md_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/exe_muldiv_sequencer_twos_negate.sv
// Conditional two's-complement negate: out = cond ? -in : in (mod 2^W).
// Ports: cond (negate enable), in (operand), out (result).
module twos_negate #(
  parameter int W = 32
) (
  input  logic         cond,
  input  logic [W-1:0] in,
  output logic [W-1:0] out
);

  assign out = cond ? (~in + W'(1)) : in;

endmodule

// File: rtl/exe_muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer beside the EXE ALU; stalls the
// front of the pipe while iterating, then commits the result to hi/lo.
// Ports: clk, reset (async high), start, op, rs_val, rt_val ->
//        stall, busy, done, div_by_zero, hi, lo.
// Option: define MULDIV_EARLY_OUT_EN to end multiply RUN once mplier is 0.
module exe_muldiv_sequencer
  import exe_muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = MD_WORDLENGTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = md_cnt_w(WIDTH);
  localparam int W2 = 2 * WIDTH;

  logic [1:0]       state_q;
  logic [CW-1:0]    cnt_q;
  logic [W2-1:0]    acc_q;
  logic [W2-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic             is_mul_q;
  logic             neg_res_q;
  logic             neg_rem_q;
  logic             dbz_q;

  logic             sgn_in;
  logic [WIDTH-1:0] rs_abs;
  logic [WIDTH-1:0] rt_abs;

  assign sgn_in = md_is_signed(op);

  twos_negate #(.W(WIDTH)) u_abs_rs (
    .cond (sgn_in & rs_val[WIDTH-1]),
    .in   (rs_val),
    .out  (rs_abs)
  );

  twos_negate #(.W(WIDTH)) u_abs_rt (
    .cond (sgn_in & rt_val[WIDTH-1]),
    .in   (rt_val),
    .out  (rt_abs)
  );

  // Multiply step: acc is the product, mcand shifts up, mplier shifts down.
  logic [W2-1:0]    mul_acc_nxt;
  logic [WIDTH-1:0] mplier_nxt;

  assign mul_acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mplier_nxt  = mplier_q >> 1;

  // Divide step: acc = {R, Q}, mplier_q holds the divisor.
  // The shifted remainder needs WIDTH+1 bits before the trial subtract.
  logic [WIDTH:0]   div_shift;
  logic             div_fits;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  assign div_shift = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
  assign div_fits  = div_shift >= {1'b0, mplier_q};
  assign rem_nxt   = div_fits
                   ? WIDTH'(div_shift - {1'b0, mplier_q})
                   : div_shift[WIDTH-1:0];
  assign quo_nxt   = {acc_q[WIDTH-2:0], div_fits};

  logic last_iter;

`ifdef MULDIV_EARLY_OUT_EN
  assign last_iter = (cnt_q == CW'(WIDTH - 1))
                   | (is_mul_q & (mplier_nxt == '0));
`else
  assign last_iter = (cnt_q == CW'(WIDTH - 1));
`endif

  // Sign correction; neg_* flags are only ever set for signed ops.
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  twos_negate #(.W(W2)) u_fix_prod (
    .cond (neg_res_q),
    .in   (acc_q),
    .out  (prod_fix)
  );

  twos_negate #(.W(WIDTH)) u_fix_quo (
    .cond (neg_res_q),
    .in   (acc_q[WIDTH-1:0]),
    .out  (quo_fix)
  );

  twos_negate #(.W(WIDTH)) u_fix_rem (
    .cond (neg_rem_q),
    .in   (acc_q[W2-1:WIDTH]),
    .out  (rem_fix)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      is_mul_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      unique case (state_q)
        MD_IDLE: begin
          if (start) begin
            is_mul_q  <= ~op[1];
            neg_res_q <= sgn_in & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
            neg_rem_q <= sgn_in & rs_val[WIDTH-1];
            cnt_q     <= '0;
            mplier_q  <= rt_abs;
            if (op[1] && rt_val == '0) begin
              hi      <= rs_val;
              lo      <= '1;
              dbz_q   <= 1'b1;
              state_q <= MD_DONE;
            end else begin
              if (op[1]) begin
                acc_q <= {{WIDTH{1'b0}}, rs_abs};
              end else begin
                acc_q <= '0;
              end
              mcand_q <= {{WIDTH{1'b0}}, rs_abs};
              state_q <= MD_RUN;
            end
          end
        end
        MD_RUN: begin
          cnt_q <= cnt_q + CW'(1);
          if (is_mul_q) begin
            acc_q    <= mul_acc_nxt;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_nxt;
          end else begin
            acc_q <= {rem_nxt, quo_nxt};
          end
          if (last_iter) begin
            state_q <= MD_FIX;
          end
        end
        MD_FIX: begin
          if (is_mul_q) begin
            hi <= prod_fix[W2-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
          state_q <= MD_DONE;
        end
        MD_DONE: begin
          dbz_q   <= 1'b0;
          state_q <= MD_IDLE;
        end
      endcase
    end
  end

  assign stall = (start & (state_q == MD_IDLE))
               | (state_q == MD_RUN)
               | (state_q == MD_FIX);
  assign busy        = state_q != MD_IDLE;
  assign done        = state_q == MD_DONE;
  assign div_by_zero = done & dbz_q;

endmodule
